// File: rtl/half_divide.sv
// Iterative binary16 divider: restoring radix-2 mantissa division, one quotient
// bit per clock, truncating, no subnormals, saturating overflow.
module half_divide #(
  parameter logic [14:0] DIV0_MAG = 15'h7FFF
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [15:0] a,
  input  logic [15:0] b,
  output logic        out_valid,
  output logic [15:0] c,
  output logic [1:0]  o_dbg_state
);

  // Handshake: an operand transfer happens at a posedge where in_valid && in_ready.
  // in_ready is high only in IDLE with rstn high; out_valid is a one-cycle pulse
  // and c holds its value until the next result.

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DIV  = 2'd1,
    PACK = 2'd2
  } state_t;

  state_t             r_state;
  logic               r_sign;
  logic               r_a_zero;
  logic               r_b_zero;
  logic signed [6:0]  r_exp;
  logic [10:0]        r_mb;
  logic [11:0]        r_rem;
  logic [11:0]        r_q;
  logic [3:0]         r_cnt;

  logic               w_rem_ge;
  logic [11:0]        w_rem_next;
  logic signed [6:0]  w_e;
  logic [9:0]         w_mant;
  logic [15:0]        w_result;

  assign in_ready    = rstn && (r_state == IDLE);
  assign o_dbg_state = r_state;

  assign w_rem_ge   = (r_rem >= {1'b0, r_mb});
  assign w_rem_next = w_rem_ge ? (r_rem - {1'b0, r_mb}) : r_rem;

  // q[11] tells whether the mantissa ratio landed in [1,2) or [0.5,1).
  assign w_e    = r_exp + (r_q[11] ? 7'sd15 : 7'sd14);
  assign w_mant = r_q[11] ? r_q[10:1] : r_q[9:0];

  always_comb begin
    w_result = 16'h0000;
    if (r_a_zero) begin
      w_result = 16'h0000;
    end else if (r_b_zero) begin
      w_result = {r_sign, DIV0_MAG};
    end else if (w_e <= 7'sd0) begin
      w_result = {r_sign, 15'h0000};
    end else if (w_e >= 7'sd31) begin
      w_result = {r_sign, 5'h1F, 10'h3FF};
    end else begin
      w_result = {r_sign, w_e[4:0], w_mant};
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_state   <= IDLE;
      r_sign    <= 1'b0;
      r_a_zero  <= 1'b0;
      r_b_zero  <= 1'b0;
      r_exp     <= 7'sd0;
      r_mb      <= 11'h000;
      r_rem     <= 12'h000;
      r_q       <= 12'h000;
      r_cnt     <= 4'd0;
      out_valid <= 1'b0;
      c         <= 16'h0000;
    end else begin
      out_valid <= 1'b0;
      case (r_state)
        IDLE: begin
          if (in_valid) begin
            r_sign   <= a[15] ^ b[15];
            r_a_zero <= (a[14:0] == 15'h0000);
            r_b_zero <= (b[14:0] == 15'h0000);
            r_exp    <= {2'b00, a[14:10]} - {2'b00, b[14:10]};
            r_mb     <= {1'b1, b[9:0]};
            r_rem    <= {2'b01, a[9:0]};
            r_q      <= 12'h000;
            r_cnt    <= 4'd11;
            r_state  <= DIV;
          end
        end
        DIV: begin
          r_q   <= {r_q[10:0], w_rem_ge};
          // The partial remainder is always below mb here, so bit 11 is zero.
          r_rem <= {w_rem_next[10:0], 1'b0};
          if (r_cnt == 4'd0) begin
            r_state <= PACK;
          end else begin
            r_cnt <= r_cnt - 4'd1;
          end
        end
        PACK: begin
          c         <= w_result;
          out_valid <= 1'b1;
          r_state   <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_half_divide.sv
// Directed bench for half_divide: latency/handshake windows, special cases,
// chained transfers with in_valid held, and reset mid-divide.
module tb_half_divide;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] a = 16'h0000;
  logic [15:0] b = 16'h0000;
  logic        out_valid;
  logic [15:0] c;
  logic [1:0]  o_dbg_state;

  int vectors = 0;
  int miscompares = 0;
  logic [15:0] last_c = 16'h0000;

  half_divide dut (
    .clk        (clk),
    .rstn       (rstn),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .a          (a),
    .b          (b),
    .out_valid  (out_valid),
    .c          (c),
    .o_dbg_state(o_dbg_state)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Present operands at a negedge once in_ready is seen; returns right after transfer edge k.
  task automatic start_op(input logic [15:0] ta, input logic [15:0] tb_v);
    int n;
    n = 0;
    @(negedge clk);
    while (!in_ready && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk("ready_wait", {15'h0, in_ready}, 16'h0001);
    in_valid = 1'b1;
    a = ta;
    b = tb_v;
    @(posedge clk);
  endtask

  // Observe the 14 negedges that precede edges k+1..k+14. With hold set, in_valid stays
  // high with junk operands and the next operands are presented before edge k+14.
  task automatic watch(input logic [15:0] exp_c, input bit hold,
                       input logic [15:0] na, input logic [15:0] nb);
    for (int j = 1; j <= 14; j++) begin
      @(negedge clk);
      if (!hold && j == 1) in_valid = 1'b0;
      if (hold) begin
        if (j == 14) begin
          a = na;
          b = nb;
        end else begin
          a = 16'(16'h5000 + j * 16'h0111);
          b = 16'(16'h3C00 + j);
        end
      end
      chk($sformatf("in_ready_e%0d", j), {15'h0, in_ready}, {15'h0, (j == 14)});
      chk($sformatf("out_valid_e%0d", j), {15'h0, out_valid}, {15'h0, (j == 14)});
      if (j == 7) chk("c_hold", c, last_c);
    end
    chk("c_result", c, exp_c);
    last_c = exp_c;
  endtask

  logic [15:0] va [11] = '{16'h4200, 16'h3C00, 16'hC600, 16'h7BFF, 16'h0400, 16'h7800,
                           16'hBC00, 16'h3C00, 16'h0000, 16'h8000, 16'h0200};
  logic [15:0] vb [11] = '{16'h3E00, 16'h4200, 16'h4000, 16'h0400, 16'h7800, 16'h3800,
                           16'h0000, 16'h8000, 16'h0000, 16'h4000, 16'h0200};
  logic [15:0] vc [11] = '{16'h4000, 16'h3555, 16'hC200, 16'h7FFF, 16'h0000, 16'h7FFF,
                           16'hFFFF, 16'hFFFF, 16'h0000, 16'h0000, 16'h3C00};

  initial begin
    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_c", c, 16'h0000);
    chk("rst_out_valid", {15'h0, out_valid}, 16'h0000);
    chk("rst_in_ready", {15'h0, in_ready}, 16'h0000);
    chk("rst_state", {14'h0, o_dbg_state}, 16'h0000);
    rstn = 1'b1;
    @(negedge clk);
    chk("ready_after_rst", {15'h0, in_ready}, 16'h0001);

    // Directed vectors, one op at a time
    for (int i = 0; i < 11; i++) begin
      start_op(va[i], vb[i]);
      watch(vc[i], 1'b0, 16'h0000, 16'h0000);
    end

    // Exponent field 31 treated as an ordinary number
    start_op(16'h7C00, 16'h7C00);
    watch(16'h3C00, 1'b0, 16'h0000, 16'h0000);
    start_op(16'hC600, 16'h4000);
    watch(16'hC200, 1'b0, 16'h0000, 16'h0000);

    // Back-to-back with in_valid held high: transfers at k and k+14 only
    start_op(16'h4200, 16'h3E00);
    watch(16'h4000, 1'b1, 16'h3C00, 16'h4200);
    @(posedge clk);
    watch(16'h3555, 1'b0, 16'h0000, 16'h0000);
    @(negedge clk);
    chk("pulse_end", {15'h0, out_valid}, 16'h0000);
    chk("c_hold_after", c, 16'h3555);

    // Reset asserted for one edge (k+5) in the middle of a divide
    start_op(16'h3C00, 16'h4200);
    for (int j = 1; j <= 5; j++) begin
      @(negedge clk);
      if (j == 1) in_valid = 1'b0;
    end
    rstn = 1'b0;
    @(negedge clk);
    chk("midrst_in_ready", {15'h0, in_ready}, 16'h0000);
    chk("midrst_c", c, 16'h0000);
    chk("midrst_state", {14'h0, o_dbg_state}, 16'h0000);
    rstn = 1'b1;
    @(negedge clk);
    chk("midrst_ready_after", {15'h0, in_ready}, 16'h0001);
    begin
      int pulses;
      pulses = 0;
      for (int j = 0; j < 16; j++) begin
        @(negedge clk);
        if (out_valid) pulses++;
      end
      chk("midrst_no_pulse", 16'(pulses), 16'h0000);
    end
    last_c = 16'h0000;
    start_op(16'h4200, 16'h3E00);
    watch(16'h4000, 1'b0, 16'h0000, 16'h0000);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
